// File: rtl/grf_wb_pkg.sv
// rtl/grf_wb_pkg.sv - shared types and constants for the register file writeback front end
package grf_wb_pkg;

    localparam int NREGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } wb_req_t;

    localparam int REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular request buffer with per-entry valid/address taps for pending checks
module wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         push,
    input  logic [REQ_W-1:0]             push_data,
    input  logic                         pop,
    output logic [REQ_W-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [AW:0]                  count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH*$clog2(NREGS)-1:0] ent_wa
);
    localparam int RW = $clog2(NREGS);

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] off;
    logic          do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wb_req_t'(push_data);
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        off       = '0;
        ent_valid = '0;
        ent_wa    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, off} < count_q);
            ent_wa[i*RW +: RW] = mem_q[i].wa;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - merges pipeline and aux writebacks onto one register file write port (WB_TRACE_EN enables a write log)
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_wa,
    input  logic [31:0] aux_wd,
    input  logic [31:0] aux_pc,
    output logic        WE,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic [31:0] PC,
    input  logic [4:0]  qa1,
    input  logic [4:0]  qa2,
    output logic        pend1,
    output logic        pend2,
    output logic [AW:0] q_count
);
    wb_req_t             aux_req;
    wb_req_t             head_req;
    logic [REQ_W-1:0]    head_data;
    logic                fifo_full, fifo_empty;
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH*5-1:0]  ent_wa;
    logic                pipe_sel, aux_push, fifo_pop;

    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] pc_q, pc_d;

    assign aux_req   = '{wa: aux_wa, wd: aux_wd, pc: aux_pc};
    assign head_req  = wb_req_t'(head_data);
    // Readiness looks only at current occupancy: a pop on the same edge never frees a slot early.
    assign aux_ready = !Reset && !fifo_full;
    assign aux_push  = aux_valid && aux_ready && (aux_wa != REG_ZERO);
    assign pipe_sel  = pipe_we && (pipe_wa != REG_ZERO);
    assign fifo_pop  = !Reset && !pipe_sel && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push      (aux_push),
        .push_data (aux_req),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count),
        .ent_valid (ent_valid),
        .ent_wa    (ent_wa)
    );

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        pc_d = pc_q;
        if (pipe_sel) begin
            we_d = 1'b1;
            wa_d = pipe_wa;
            wd_d = pipe_wd;
            pc_d = pipe_pc;
        end else if (!fifo_empty) begin
            we_d = 1'b1;
            wa_d = head_req.wa;
            wd_d = head_req.wd;
            pc_d = head_req.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            pc_q <= '0;
        end else begin
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
            pc_q <= pc_d;
        end
    end

    assign WE = we_q;
    assign WA = wa_q;
    assign WD = wd_q;
    assign PC = pc_q;

    // The in-flight pipe request is deliberately excluded; decode forwards from WB directly.
    always_comb begin
        pend1 = we_q && (wa_q == qa1);
        pend2 = we_q && (wa_q == qa2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_wa[i*5 +: 5] == qa1)) pend1 = 1'b1;
            if (ent_valid[i] && (ent_wa[i*5 +: 5] == qa2)) pend2 = 1'b1;
        end
        if (qa1 == REG_ZERO) pend1 = 1'b0;
        if (qa2 == REG_ZERO) pend2 = 1'b0;
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (we_q) begin
            $display("%d@%h: $%d <= %h", $time, pc_q, wa_q, wd_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed vector bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd, pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_wa;
    logic [31:0] aux_wd, aux_pc;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] WD, PC;
    logic [4:0]  qa1, qa2;
    logic        pend1, pend2;
    logic [2:0]  q_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .Reset(Reset),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_wa(aux_wa), .aux_wd(aux_wd), .aux_pc(aux_pc),
        .WE(WE), .WA(WA), .WD(WD), .PC(PC),
        .qa1(qa1), .qa2(qa2), .pend1(pend1), .pend2(pend2), .q_count(q_count)
    );

    typedef struct {
        logic        pwe;
        logic [4:0]  pwa;
        logic [31:0] pwd, ppc;
        logic        av;
        logic [4:0]  awa;
        logic [31:0] awd, apc;
        logic [4:0]  q1, q2;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd, epc;
        logic        erdy, ep1, ep2;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic [31:0] ppc, input logic av, input logic [4:0] awa,
                         input logic [31:0] awd, input logic [31:0] apc,
                         input logic [4:0] q1, input logic [4:0] q2);
        @(negedge clk);
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd; pipe_pc = ppc;
        aux_valid = av; aux_wa = awa; aux_wd = awd; aux_pc = apc;
        qa1 = q1; qa2 = q2;
        #1;
        if (pwe && pwa != 5'd0 && pwa == q1) chk("contract_pend1", {31'd0, pend1}, 32'd0);
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, q1, q2);
    endtask

    function automatic vec_t mk(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                                input logic [31:0] ppc, input logic av, input logic [4:0] awa,
                                input logic [31:0] awd, input logic [31:0] apc,
                                input logic [4:0] q1, input logic [4:0] q2,
                                input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                                input logic [31:0] epc, input logic erdy, input logic ep1,
                                input logic ep2, input logic [2:0] ecnt);
        vec_t v;
        v.pwe = pwe; v.pwa = pwa; v.pwd = pwd; v.ppc = ppc;
        v.av = av; v.awa = awa; v.awd = awd; v.apc = apc; v.q1 = q1; v.q2 = q2;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.epc = epc;
        v.erdy = erdy; v.ep1 = ep1; v.ep2 = ep2; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        // pipe write, then single aux write, then $0 writes, then pipe/aux collision
        vt[0]  = mk(0,0,0,0,            0,0,0,0,          5,0, 0,0,0,0,                      1,0,0,0);
        vt[1]  = mk(1,5,32'hDEADBEEF,32'h3000, 0,0,0,0,   5,0, 0,0,0,0,                      1,0,0,0);
        vt[2]  = mk(0,0,0,0,            0,0,0,0,          5,5, 1,5,32'hDEADBEEF,32'h3000,    1,1,1,0);
        vt[3]  = mk(0,0,0,0,            0,0,0,0,          5,0, 0,5,32'hDEADBEEF,32'h3000,    1,0,0,0);
        vt[4]  = mk(0,0,0,0,            1,8,32'h12,32'h4000, 8,0, 0,5,32'hDEADBEEF,32'h3000, 1,0,0,0);
        vt[5]  = mk(0,0,0,0,            0,0,0,0,          8,8, 0,5,32'hDEADBEEF,32'h3000,    1,1,1,1);
        vt[6]  = mk(0,0,0,0,            0,0,0,0,          8,0, 1,8,32'h12,32'h4000,          1,1,0,0);
        vt[7]  = mk(0,0,0,0,            0,0,0,0,          8,0, 0,8,32'h12,32'h4000,          1,0,0,0);
        vt[8]  = mk(1,0,32'h55,32'h5000, 1,0,32'h66,32'h6000, 0,8, 0,8,32'h12,32'h4000,      1,0,0,0);
        vt[9]  = mk(0,0,0,0,            0,0,0,0,          0,0, 0,8,32'h12,32'h4000,          1,0,0,0);
        vt[10] = mk(1,3,32'hA,32'h7000, 1,9,32'hB,32'h7004, 9,3, 0,8,32'h12,32'h4000,        1,0,0,0);
        vt[11] = mk(0,0,0,0,            0,0,0,0,          9,3, 1,3,32'hA,32'h7000,           1,1,1,1);
        vt[12] = mk(0,0,0,0,            0,0,0,0,          9,3, 1,9,32'hB,32'h7004,           1,1,0,0);
        vt[13] = mk(0,0,0,0,            0,0,0,0,          9,3, 0,9,32'hB,32'h7004,           1,0,0,0);

        Reset = 1'b1;
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("rst_we", {31'd0, WE}, 32'd0);
        chk("rst_wa", {27'd0, WA}, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_ready", {31'd0, aux_ready}, 32'd0);
        chk("rst_count", {29'd0, q_count}, 32'd0);
        chk("rst_pend1", {31'd0, pend1}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].pwe, vt[i].pwa, vt[i].pwd, vt[i].ppc, vt[i].av, vt[i].awa,
                  vt[i].awd, vt[i].apc, vt[i].q1, vt[i].q2);
            chk($sformatf("v%0d_we", i), {31'd0, WE}, {31'd0, vt[i].ewe});
            chk($sformatf("v%0d_wa", i), {27'd0, WA}, {27'd0, vt[i].ewa});
            chk($sformatf("v%0d_wd", i), WD, vt[i].ewd);
            chk($sformatf("v%0d_pc", i), PC, vt[i].epc);
            chk($sformatf("v%0d_ready", i), {31'd0, aux_ready}, {31'd0, vt[i].erdy});
            chk($sformatf("v%0d_pend1", i), {31'd0, pend1}, {31'd0, vt[i].ep1});
            chk($sformatf("v%0d_pend2", i), {31'd0, pend2}, {31'd0, vt[i].ep2});
            chk($sformatf("v%0d_count", i), {29'd0, q_count}, {29'd0, vt[i].ecnt});
        end

        // pipe busy 6 cycles while 5 aux requests are offered: fill, stall, drain in order
        for (int k = 0; k < 6; k++) begin
            int n;
            n = (k < 4) ? k : 4;
            drive(1'b1, 5'(10 + k), 32'(k), 32'h8000 + 32'(4 * k), 1'b1, 5'(20 + n),
                  32'(100 + n), 32'h9000 + 32'(4 * n), 5'd0, 5'd0);
            chk($sformatf("fill%0d_ready", k), {31'd0, aux_ready}, {31'd0, (k < 4)});
            chk($sformatf("fill%0d_count", k), {29'd0, q_count}, 32'(n));
            if (k > 0) chk($sformatf("fill%0d_wa", k), {27'd0, WA}, 32'(10 + k - 1));
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd24, 32'd104, 32'h9010, 5'd23, 5'd24);
        chk("full_noready", {31'd0, aux_ready}, 32'd0);
        chk("full_count", {29'd0, q_count}, 32'd4);
        chk("full_wa_pipe", {27'd0, WA}, 32'd15);
        chk("full_pend_q", {31'd0, pend1}, 32'd1);
        chk("full_pend_5th", {31'd0, pend2}, 32'd0);
        for (int j = 0; j < 5; j++) begin
            logic [2:0] ec;
            ec = (j == 0) ? 3'd3 : 3'(4 - j);
            drive(1'b0, 5'd0, 32'd0, 32'd0, (j == 0), 5'd24, 32'd104, 32'h9010, 5'd0, 5'd0);
            if (j == 0) chk("drain_ready", {31'd0, aux_ready}, 32'd1);
            chk($sformatf("drain%0d_we", j), {31'd0, WE}, 32'd1);
            chk($sformatf("drain%0d_wa", j), {27'd0, WA}, 32'(20 + j));
            chk($sformatf("drain%0d_wd", j), WD, 32'(100 + j));
            chk($sformatf("drain%0d_pc", j), PC, 32'h9000 + 32'(4 * j));
            chk($sformatf("drain%0d_count", j), {29'd0, q_count}, {29'd0, ec});
        end
        idle(5'd0, 5'd0);
        chk("drained_we", {31'd0, WE}, 32'd0);

        // reset with 3 queued entries and a live write: nothing queued may ever surface
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(1 + k), 32'hC0 + 32'(k), 32'hA000, (k < 3), 5'(25 + k),
                  32'hE0 + 32'(k), 32'hB000, 5'd0, 5'd0);
        end
        idle(5'd25, 5'd27);
        chk("prerst_we", {31'd0, WE}, 32'd1);
        chk("prerst_wa", {27'd0, WA}, 32'd4);
        chk("prerst_count", {29'd0, q_count}, 32'd3);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("inrst_ready", {31'd0, aux_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("postrst_we", {31'd0, WE}, 32'd0);
        chk("postrst_wa", {27'd0, WA}, 32'd0);
        chk("postrst_count", {29'd0, q_count}, 32'd0);
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle(5'd25, 5'd27);
            chk($sformatf("after_rst%0d_we", k), {31'd0, WE}, 32'd0);
            chk($sformatf("after_rst%0d_pend", k), {30'd0, pend1, pend2}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
